// File: rtl/zcu216_clk_pkg.sv
// -----------------------------------------------------------------------------
// zcu216_clk_pkg
// Shared types and defaults for the zcu216 clock-infrastructure control logic.
//   - ps_state_e          : phase-shift sequencer states
//   - DEF_*               : default parameter values for the sequencer
//   - cnt_w()             : width of a counter that must hold 0..max
// -----------------------------------------------------------------------------
package zcu216_clk_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_IDLE      = 3'd1,
    ST_CMP       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SETTLE    = 3'd4
  } ps_state_e;

  localparam int unsigned DEF_POS_W         = 16;
  // UG572 guarantees PSDONE within 12 PSCLK cycles; leave generous margin.
  localparam int unsigned DEF_DONE_TIMEOUT  = 32;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_LOCK_WAIT     = 1024;

  // Bits needed for a counter that counts from 0 up to and including max.
  function automatic int unsigned cnt_w(input int unsigned max);
    int unsigned w;
    if (max < 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(max + 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/zcu216_lock_monitor.sv
// -----------------------------------------------------------------------------
// zcu216_lock_monitor
// Brings MMCM LOCKED into the PSCLK domain and qualifies it: lock is only
// reported good once the synchronised level has been high for LOCK_WAIT
// consecutive cycles. Any low sample restarts the qualification.
// Ports:
//   clk         in  PSCLK
//   rst_n       in  asynchronous active-low reset
//   mmcm_locked in  raw MMCM LOCKED (asynchronous to clk)
//   lock_ok     out synchronised lock has been stable for LOCK_WAIT cycles
//   lock_lost   out one-cycle pulse on the synchronised high->low transition
// -----------------------------------------------------------------------------
module zcu216_lock_monitor
  import zcu216_clk_pkg::*;
#(
  parameter int unsigned LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mmcm_locked,
  output logic lock_ok,
  output logic lock_lost
);

  localparam int unsigned       CW          = cnt_w(LOCK_WAIT);
  localparam logic [CW-1:0]     LOCK_WAIT_C = CW'(LOCK_WAIT);

  logic          sync1_q;
  logic          sync2_q;
  logic          sync_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-stage synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync1_q     <= mmcm_locked;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  // Consecutive-high counter; saturates at LOCK_WAIT, clears on a low sample.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != LOCK_WAIT_C) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Qualification counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gate with the live level so a drop is never reported as good lock, even
  // in the cycle before the counter clears.
  assign lock_ok   = sync2_q & (cnt_q == LOCK_WAIT_C);
  assign lock_lost = sync_prev_q & ~sync2_q;

endmodule

// File: rtl/zcu216_mmcm_phase_shift_ctrl.sv
// -----------------------------------------------------------------------------
// zcu216_mmcm_phase_shift_ctrl
// Walks the MMCM dynamic fine phase shift one step at a time until the tracked
// position equals a software-requested signed target. Only one step is ever
// outstanding; a missing PSDONE or loss of lock aborts the move.
// Ports:
//   clk         in  PSCLK
//   rst_n       in  asynchronous active-low reset
//   mmcm_locked in  MMCM LOCKED (raw; synchronised internally)
//   start       in  one-cycle request to move to target
//   target      in  signed absolute target position (POS_W)
//   psen        out one-cycle phase-shift enable to the MMCM
//   psincdec    out step direction, 1 = increment; valid with psen
//   psdone      in  MMCM step-complete pulse
//   busy        out move in progress
//   done        out one-cycle pulse when the target is reached
//   error       out sticky timeout / lock-loss flag, cleared by next start
//   cur_pos     out signed tracked position (POS_W)
//   pos_valid   out cur_pos reflects the real MMCM phase
// -----------------------------------------------------------------------------
module zcu216_mmcm_phase_shift_ctrl
  import zcu216_clk_pkg::*;
#(
  parameter int unsigned POS_W         = DEF_POS_W,
  parameter int unsigned DONE_TIMEOUT  = DEF_DONE_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,  // must be >= 1
  parameter int unsigned LOCK_WAIT     = DEF_LOCK_WAIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mmcm_locked,
  input  logic             start,
  input  logic [POS_W-1:0] target,
  output logic             psen,
  output logic             psincdec,
  input  logic             psdone,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [POS_W-1:0] cur_pos,
  output logic             pos_valid
);

  localparam int unsigned   TW       = cnt_w(DONE_TIMEOUT);
  localparam int unsigned   SW       = cnt_w(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 32'd1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 32'd1);

  ps_state_e        state_q,     state_d;
  logic [POS_W-1:0] cur_pos_q,   cur_pos_d;
  logic [POS_W-1:0] target_q,    target_d;
  logic             pos_valid_q, pos_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             error_q,     error_d;
  logic             psen_q,      psen_d;
  logic             psincdec_q,  psincdec_d;
  logic [TW-1:0]    tmo_q,       tmo_d;
  logic [SW-1:0]    settle_q,    settle_d;

  logic             lock_ok_s;
  logic             lock_lost_s;
  logic [POS_W:0]   diff_s;

  zcu216_lock_monitor #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_monitor (
    .clk         (clk),
    .rst_n       (rst_n),
    .mmcm_locked (mmcm_locked),
    .lock_ok     (lock_ok_s),
    .lock_lost   (lock_lost_s)
  );

  // One extra bit so the full signed span of target - cur_pos never overflows.
  assign diff_s = {target_q[POS_W-1], target_q} - {cur_pos_q[POS_W-1], cur_pos_q};

  // Sequencer next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cur_pos_d   = cur_pos_q;
    target_d    = target_q;
    pos_valid_d = pos_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    psen_d      = 1'b0;
    psincdec_d  = psincdec_q;
    tmo_d       = tmo_q;
    settle_d    = settle_q;

    // Lock loss overrides everything, including a coincident psdone: the
    // phase after re-lock is the MMCM's power-on phase, i.e. position 0.
    if ((state_q != ST_WAIT_LOCK) && lock_lost_s) begin
      state_d     = ST_WAIT_LOCK;
      cur_pos_d   = '0;
      pos_valid_d = 1'b0;
      busy_d      = 1'b0;
      error_d     = error_q | busy_q;
      tmo_d       = '0;
      settle_d    = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_ok_s) begin
            pos_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d     = ST_WAIT_LOCK;
          end
        end

        ST_IDLE: begin
          if (start && pos_valid_q) begin
            target_d = target;
            error_d  = 1'b0;
            busy_d   = 1'b1;
            state_d  = ST_CMP;
          end else begin
            state_d  = ST_IDLE;
          end
        end

        ST_CMP: begin
          if (diff_s == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            psen_d     = 1'b1;
            psincdec_d = ~diff_s[POS_W];
            tmo_d      = '0;
            state_d    = ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (psdone) begin
            if (psincdec_q) begin
              cur_pos_d = cur_pos_q + POS_W'(1);
            end else begin
              cur_pos_d = cur_pos_q - POS_W'(1);
            end
            settle_d = '0;
            state_d  = ST_SETTLE;
          end else if (tmo_q == TMO_LAST) begin
            // The step may or may not have landed, so the position is untrusted.
            error_d     = 1'b1;
            busy_d      = 1'b0;
            pos_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end

        ST_SETTLE: begin
          if (settle_q == SET_LAST) begin
            state_d = ST_CMP;
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end

        default: begin
          state_d     = ST_WAIT_LOCK;
          cur_pos_d   = '0;
          pos_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_LOCK;
      cur_pos_q   <= '0;
      target_q    <= '0;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      psen_q      <= 1'b0;
      psincdec_q  <= 1'b0;
      tmo_q       <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_pos_q   <= cur_pos_d;
      target_q    <= target_d;
      pos_valid_q <= pos_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      psen_q      <= psen_d;
      psincdec_q  <= psincdec_d;
      tmo_q       <= tmo_d;
      settle_q    <= settle_d;
    end
  end

  assign psen      = psen_q;
  assign psincdec  = psincdec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cur_pos   = cur_pos_q;
  assign pos_valid = pos_valid_q;

endmodule

// File: tb/tb_zcu216_mmcm_phase_shift_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for zcu216_mmcm_phase_shift_ctrl. An MMCM responder
// answers each psen with psdone after a programmable latency; a monitor logs
// every psen/done. Expectations come from a position model: a move from p to t
// must produce |t-p| steps in the sign of t-p and exactly one done.
// -----------------------------------------------------------------------------
module tb_zcu216_mmcm_phase_shift_ctrl;

  localparam int POS_W         = 16;
  localparam int DONE_TIMEOUT  = 32;
  localparam int SETTLE_CYCLES = 4;
  localparam int LOCK_WAIT     = 1024;

  logic clk = 1'b0;
  logic rst_n;
  logic mmcm_locked;
  logic start;
  logic signed [POS_W-1:0] target;
  logic psen;
  logic psincdec;
  logic psdone;
  logic psdone_rsp  = 1'b0;
  logic psdone_spur = 1'b0;
  logic busy;
  logic done;
  logic error;
  logic signed [POS_W-1:0] cur_pos;
  logic pos_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat       = 5;
  int ack_limit = 1 << 30;
  int rsp_cnt   = 0;
  int psen_t[$];
  bit psen_inc[$];
  int done_t[$];
  int model_pos = 0;

  assign psdone = psdone_rsp | psdone_spur;

  zcu216_mmcm_phase_shift_ctrl #(
    .POS_W         (POS_W),
    .DONE_TIMEOUT  (DONE_TIMEOUT),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .LOCK_WAIT     (LOCK_WAIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mmcm_locked (mmcm_locked),
    .start       (start),
    .target      (target),
    .psen        (psen),
    .psincdec    (psincdec),
    .psdone      (psdone),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cur_pos     (cur_pos),
    .pos_valid   (pos_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log psen pulses (time, direction) and done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (psen) begin
        psen_t.push_back(cyc);
        psen_inc.push_back(psincdec);
      end
      if (done) done_t.push_back(cyc);
    end
  end

  // MMCM model: psdone lat cycles after psen, for the first ack_limit steps.
  initial begin
    forever begin
      @(negedge clk);
      if (psen && rst_n && (rsp_cnt < ack_limit)) begin
        rsp_cnt = rsp_cnt + 1;
        repeat (lat - 1) @(negedge clk);
        psdone_rsp = 1'b1;
        @(negedge clk);
        psdone_rsp = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller has just released reset or raised lock at a negedge.
  task automatic wait_valid(input string tag);
    int k = 0;
    while (!pos_valid && k < LOCK_WAIT + 200) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_lockwait_window"}, longint'(k >= LOCK_WAIT + 1 && k <= LOCK_WAIT + 4), 1);
  endtask

  task automatic move(input int t, input int l);
    int p0, d0, k, steps, ninc, ndec, mingap;
    lat = l;
    p0  = psen_t.size();
    d0  = done_t.size();
    @(negedge clk);
    target = POS_W'(t);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check_val("move_done_seen", longint'(k < 5000), 1);
    @(negedge clk);
    steps  = (t > model_pos) ? (t - model_pos) : (model_pos - t);
    ninc   = 0;
    ndec   = 0;
    mingap = 1 << 30;
    for (int i = p0; i < psen_t.size(); i++) begin
      if (psen_inc[i]) ninc++;
      else ndec++;
      if (i > p0 && (psen_t[i] - psen_t[i-1]) < mingap) mingap = psen_t[i] - psen_t[i-1];
    end
    check_val("move_psen_cnt", psen_t.size() - p0, steps);
    check_val("move_inc_cnt", ninc, (t > model_pos) ? steps : 0);
    check_val("move_dec_cnt", ndec, (t < model_pos) ? steps : 0);
    check_val("move_done_cnt", done_t.size() - d0, 1);
    check_val("move_cur_pos", cur_pos, t);
    check_val("move_error", error, 0);
    check_val("move_busy", busy, 0);
    if (steps > 1) check_val("move_psen_gap", longint'(mingap >= 1 + l + SETTLE_CYCLES), 1);
    model_pos = t;
  endtask

  initial begin
    int p0, d0, k, seen, t;
    rst_n       = 1'b0;
    mmcm_locked = 1'b1;
    start       = 1'b0;
    target      = '0;
    repeat (3) @(negedge clk);
    check_val("rst_psen", psen, 0);
    check_val("rst_psincdec", psincdec, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_cur_pos", cur_pos, 0);
    check_val("rst_pos_valid", pos_valid, 0);
    rst_n = 1'b1;
    wait_valid("init");
    model_pos = 0;

    move(3, 5);
    move(-2, 5);

    // Target equal to current position: done two cycles after start, no psen.
    p0 = psen_t.size();
    @(negedge clk);
    target = -16'sd2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("zero_done_c1", done, 0);
    check_val("zero_busy_c1", busy, 1);
    @(negedge clk);
    check_val("zero_done_c2", done, 1);
    @(negedge clk);
    check_val("zero_done_c3", done, 0);
    check_val("zero_busy_c3", busy, 0);
    check_val("zero_psen_cnt", psen_t.size() - p0, 0);

    // start while busy must not re-latch; then a spurious psdone in IDLE.
    p0  = psen_t.size();
    d0  = done_t.size();
    lat = 3;
    @(negedge clk);
    target = 16'sd4;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    target = -16'sd7;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_val("busy_start_psen_cnt", psen_t.size() - p0, 4 - model_pos);
    check_val("busy_start_pos", cur_pos, 4);
    check_val("busy_start_done_cnt", done_t.size() - d0, 1);
    model_pos = 4;
    p0 = psen_t.size();
    psdone_spur = 1'b1;
    @(negedge clk);
    psdone_spur = 1'b0;
    repeat (3) @(negedge clk);
    check_val("spur_pos", cur_pos, 4);
    check_val("spur_psen_cnt", psen_t.size() - p0, 0);

    // Randomised moves.
    for (int r = 0; r < 5; r++) begin
      t = int'($urandom_range(30, 0)) - 15;
      move(t, int'($urandom_range(6, 1)));
    end

    // Lock loss during WAIT_DONE of a 10-step move.
    p0  = psen_t.size();
    d0  = done_t.size();
    lat = 5;
    @(negedge clk);
    target = POS_W'(model_pos + 10);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (psen_t.size() < p0 + 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    mmcm_locked = 1'b0;
    repeat (10) @(negedge clk);
    check_val("lol_error", error, 1);
    check_val("lol_busy", busy, 0);
    check_val("lol_pos_valid", pos_valid, 0);
    check_val("lol_cur_pos", cur_pos, 0);
    check_val("lol_done_cnt", done_t.size() - d0, 0);
    check_val("lol_psen_cnt", psen_t.size() - p0, 3);
    model_pos = 0;
    mmcm_locked = 1'b1;
    wait_valid("relock");
    check_val("relock_error_sticky", error, 1);

    // Timeout: psdone withheld after the second psen.
    ack_limit = rsp_cnt + 1;
    lat = 3;
    p0  = psen_t.size();
    d0  = done_t.size();
    @(negedge clk);
    target = 16'sd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    k    = 0;
    while (seen < 2 && k < 500) begin
      @(negedge clk);
      k++;
      if (psen) seen++;
    end
    check_val("tmo_error_cleared", error, 0);
    k = 0;
    while (!error && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("tmo_cycles", k, DONE_TIMEOUT);
    check_val("tmo_busy", busy, 0);
    check_val("tmo_pos_valid", pos_valid, 0);
    check_val("tmo_cur_pos", cur_pos, 1);
    check_val("tmo_done_cnt", done_t.size() - d0, 0);
    ack_limit = 1 << 30;
    p0 = psen_t.size();
    @(negedge clk);
    target = 16'sd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_val("tmo_ignored_busy", busy, 0);
    check_val("tmo_ignored_psen", psen_t.size() - p0, 0);
    check_val("tmo_ignored_error", error, 1);
    mmcm_locked = 1'b0;
    repeat (6) @(negedge clk);
    check_val("tmo_recover_pos", cur_pos, 0);
    mmcm_locked = 1'b1;
    wait_valid("tmo_relock");
    model_pos = 0;

    // Asynchronous reset in the middle of a move.
    move(2, 2);
    lat = 4;
    @(negedge clk);
    target = -16'sd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    k    = 0;
    while (seen < 2 && k < 500) begin
      @(negedge clk);
      k++;
      if (psen) seen++;
    end
    check_val("arst_psen_before", psen, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_psen", psen, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_cur_pos", cur_pos, 0);
    check_val("arst_pos_valid", pos_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("arst_relock");
    model_pos = 0;
    move(6, 2);
    move(-1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
